// File: rtl/fp16_sort4.sv
// rtl/fp16_sort4.sv - four-entry FP16 sorter using a 5-pair compare-swap network
//
// Purpose: accepts four half-precision words over a valid/ready input stream,
// sorts them with a registered compare stage followed by a swap stage per
// network pair, then returns them in order over a valid/ready output stream.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_data     FP16 operand            in_valid   operand valid
//   in_ready    sorter accepts an operand (LOAD only)
//   out_data    sorted word at the drain index (0 outside DRAIN)
//   out_valid   out_data valid (DRAIN only)
//   out_ready   consumer accepts out_data
//   busy        sort in progress (CMP or SWAP)
//   swap_count  swaps performed by the last sort
module fp16_sort4 #(
  parameter bit DESCEND = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic [2:0]  swap_count
);

  typedef enum logic [1:0] {S_LOAD, S_CMP, S_SWAP, S_DRAIN} state_e;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_LT = 3'b010;
  localparam logic [2:0] CMP_EQ = 3'b001;

  state_e      state_q, state_d;
  logic [15:0] r_q [4];
  logic [15:0] r_d [4];
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  pk_q, pk_d;
  logic [2:0]  cmp_q, cmp_d;
  logic [2:0]  swap_count_q, swap_count_d;

  logic [1:0]  a_idx, b_idx;
  logic        swap_now;

  // Sign-magnitude ordering: for negatives a larger magnitude is smaller.
  function automatic logic [2:0] fp16_compare(input logic [15:0] a, input logic [15:0] b);
    if (a == b)
      return CMP_EQ;
    if (a[15] != b[15])
      return a[15] ? CMP_LT : CMP_GT;
    if (!a[15])
      return (a[14:0] > b[14:0]) ? CMP_GT : CMP_LT;
    return (a[14:0] > b[14:0]) ? CMP_LT : CMP_GT;
  endfunction

  // Network pairs: (0,1) (2,3) (0,2) (1,3) (1,2)
  always_comb begin
    a_idx = 2'd1;
    b_idx = 2'd2;
    case (pk_q)
      3'd0: begin a_idx = 2'd0; b_idx = 2'd1; end
      3'd1: begin a_idx = 2'd2; b_idx = 2'd3; end
      3'd2: begin a_idx = 2'd0; b_idx = 2'd2; end
      3'd3: begin a_idx = 2'd1; b_idx = 2'd3; end
      default: begin a_idx = 2'd1; b_idx = 2'd2; end
    endcase
  end

  // Equal words never match either code, so they are never swapped.
  assign swap_now = DESCEND ? (cmp_q == CMP_LT) : (cmp_q == CMP_GT);

  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    idx_d        = idx_q;
    pk_d         = pk_q;
    cmp_d        = cmp_q;
    swap_count_d = swap_count_q;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          r_d[idx_q] = in_data;
          if (idx_q == 2'd3) begin
            state_d      = S_CMP;
            idx_d        = 2'd0;
            pk_d         = 3'd0;
            swap_count_d = 3'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_CMP: begin
        cmp_d   = fp16_compare(r_q[a_idx], r_q[b_idx]);
        state_d = S_SWAP;
      end
      S_SWAP: begin
        if (swap_now) begin
          r_d[a_idx]   = r_q[b_idx];
          r_d[b_idx]   = r_q[a_idx];
          swap_count_d = swap_count_q + 3'd1;
        end
        if (pk_q == 3'd4) begin
          state_d = S_DRAIN;
          idx_d   = 2'd0;
        end else begin
          pk_d    = pk_q + 3'd1;
          state_d = S_CMP;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (idx_q == 2'd3) begin
            state_d = S_LOAD;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LOAD;
      r_q          <= '{default: 16'h0000};
      idx_q        <= 2'd0;
      pk_q         <= 3'd0;
      cmp_q        <= 3'd0;
      swap_count_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      idx_q        <= idx_d;
      pk_q         <= pk_d;
      cmp_q        <= cmp_d;
      swap_count_q <= swap_count_d;
    end
  end

  assign in_ready   = (state_q == S_LOAD);
  assign out_valid  = (state_q == S_DRAIN);
  assign busy       = (state_q == S_CMP) || (state_q == S_SWAP);
  assign out_data   = out_valid ? r_q[idx_q] : 16'h0000;
  assign swap_count = swap_count_q;

endmodule

// File: tb/tb_fp16_sort4.sv
// tb/tb_fp16_sort4.sv - scoreboard testbench for fp16_sort4 (ascending and descending instances)
module tb_fp16_sort4;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [15:0] in_data_a, out_data_a;
  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
  logic [2:0]  swap_count_a;

  logic [15:0] in_data_d, out_data_d;
  logic        in_valid_d, in_ready_d, out_valid_d, out_ready_d, busy_d;
  logic [2:0]  swap_count_d;

  always #5 clk = ~clk;

  fp16_sort4 #(.DESCEND(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .busy(busy_a), .swap_count(swap_count_a)
  );

  fp16_sort4 #(.DESCEND(1'b1)) dut_d (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data_d), .in_valid(in_valid_d), .in_ready(in_ready_d),
    .out_data(out_data_d), .out_valid(out_valid_d), .out_ready(out_ready_d),
    .busy(busy_d), .swap_count(swap_count_d)
  );

  typedef struct {
    logic [15:0] d;
    int          sc;   // expected swap_count, -1 = not checked
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_d[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_or  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Order-preserving integer key for FP16 bit patterns.
  function automatic logic [15:0] okey(input logic [15:0] x);
    return x[15] ? ~x : (x ^ 16'h8000);
  endfunction

  task automatic model_sort(input logic [15:0] w[4], output logic [15:0] s[4]);
    logic [15:0] t;
    s = w;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 3; j++)
        if (okey(s[j]) > okey(s[j+1])) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
  endtask

  task automatic push_a(input logic [15:0] s[4], input int sc, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.d = s[i]; e.sc = sc;
      exp_a.push_back(e);
    end
  endtask

  // Returns right after the posedge that accepts the 4th word.
  task automatic load_set(input logic [15:0] w[4], input bit gate);
    int i = 0;
    int guard = 0;
    while (i < 4 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (gate && $urandom_range(0, 2) == 0) begin
        in_valid_a = 1'b0;
        in_data_a  = 16'($urandom);
      end else begin
        in_valid_a = 1'b1;
        in_data_a  = w[i];
        if (in_ready_a) i++;
      end
    end
    check("load_timeout", (i == 4), 1);
    @(posedge clk);
    #1;
    in_valid_a = gate;
    in_data_a  = 16'hDEAD;
  endtask

  task automatic wait_idle_a(input int max);
    int c = 0;
    while ((exp_a.size() != 0 || !in_ready_a) && c < max) begin
      @(negedge clk);
      c++;
    end
    check("drain_timeout", (c < max), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready_a, 1);
    check({tag, "_out_valid"}, out_valid_a, 0);
    check({tag, "_out_data"}, out_data_a, 0);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_swap_count"}, swap_count_a, 0);
  endtask

  // Monitor for the ascending instance: handshakes, hold under backpressure.
  initial begin : mon_a
    exp_t        e;
    bit          hold = 1'b0;
    logic [15:0] held = 16'h0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", out_valid_a, 1);
          check("hold_data", out_data_a, held);
        end
        if (out_valid_a && out_ready_a) begin
          if (exp_a.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_output: got %h, expected no output", out_data_a);
          end else begin
            e = exp_a.pop_front();
            check("out_data", out_data_a, e.d);
            if (e.sc >= 0) check("swap_count", swap_count_a, e.sc);
          end
          hold = 1'b0;
        end else if (out_valid_a) begin
          hold = 1'b1;
          held = out_data_a;
        end else begin
          hold = 1'b0;
        end
      end
    end
  end

  initial begin : mon_d
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && out_valid_d && out_ready_d) begin
        if (exp_d.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_output_desc: got %h, expected no output", out_data_d);
        end else begin
          e = exp_d.pop_front();
          check("out_data_desc", out_data_d, e.d);
          check("swap_count_desc", swap_count_d, e.sc);
        end
      end
    end
  end

  initial begin : rand_ready
    forever begin
      @(negedge clk);
      if (rand_or) out_ready_a = 1'($urandom_range(0, 1));
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] w[4];
    logic [15:0] s[4];
    exp_t        e;
    int          cyc, nbusy, c;

    rst_n = 1'b0;
    in_valid_a = 1'b0; in_data_a = 16'h0; out_ready_a = 1'b0;
    in_valid_d = 1'b0; in_data_d = 16'h0; out_ready_d = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready_a, 1);
    out_ready_a = 1'b1;

    // Ascending mixed signs, with latency checks
    w = '{16'h4200, 16'h3C00, 16'hC000, 16'h4000};
    s = '{16'hC000, 16'h3C00, 16'h4000, 16'h4200};
    push_a(s, 4, 4);
    load_set(w, 1'b0);
    cyc = 0; nbusy = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("in_ready_drop", in_ready_a, 0);
      if (busy_a) nbusy++;
    end while (!out_valid_a && cyc < 40);
    check("first_valid_latency", cyc, 11);
    check("busy_cycles", nbusy, 10);
    wait_idle_a(100);

    // All equal
    w = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
    push_a(w, 0, 4);
    load_set(w, 1'b0);
    wait_idle_a(100);

    // Presorted
    w = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    push_a(w, 0, 4);
    load_set(w, 1'b0);
    wait_idle_a(100);

    // Negatives and signed zero
    w = '{16'h0000, 16'h8000, 16'hC000, 16'hC400};
    s = '{16'hC400, 16'hC000, 16'h8000, 16'h0000};
    push_a(s, 4, 4);
    load_set(w, 1'b0);
    wait_idle_a(100);

    // Descending instance
    w = '{16'h4200, 16'h3C00, 16'hC000, 16'h4000};
    s = '{16'h4200, 16'h4000, 16'h3C00, 16'hC000};
    for (int i = 0; i < 4; i++) begin
      e.d = s[i]; e.sc = 2;
      exp_d.push_back(e);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid_d = 1'b1;
      in_data_d  = w[i];
    end
    @(negedge clk);
    in_valid_d = 1'b1;
    in_data_d  = 16'h7BFF;
    c = 0;
    while (exp_d.size() != 0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    in_valid_d = 1'b0;
    check("desc_drain_timeout", (c < 100), 1);

    // Handshake stress against the reference model
    rand_or = 1'b1;
    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < 4; i++)
        w[i] = ($urandom_range(0, 3) == 0 && i > 0) ? w[0] : 16'($urandom);
      model_sort(w, s);
      push_a(s, -1, 4);
      load_set(w, 1'b1);
    end
    @(negedge clk);
    in_valid_a = 1'b0;
    wait_idle_a(5000);
    rand_ready_off: begin
      @(negedge clk);
      rand_or = 1'b0;
      out_ready_a = 1'b1;
    end

    // Reset mid-sort at cycle T+5
    w = '{16'h1234, 16'h8001, 16'h7C00, 16'h0400};
    load_set(w, 1'b0);
    repeat (5) @(negedge clk);
    check("midsort_busy_before", busy_a, 1);
    rst_n = 1'b0;
    exp_a.delete();
    #1;
    check_reset_outputs("midsort_rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_outputs("midsort_after");

    // Reset mid-drain after two transfers
    out_ready_a = 1'b0;
    w = '{16'h4200, 16'h3C00, 16'hC000, 16'h4000};
    s = '{16'hC000, 16'h3C00, 16'h4000, 16'h4200};
    push_a(s, 4, 2);
    load_set(w, 1'b0);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!out_valid_a && c < 40);
    check("middrain_valid", out_valid_a, 1);
    out_ready_a = 1'b1;
    repeat (2) @(negedge clk);
    out_ready_a = 1'b0;
    rst_n = 1'b0;
    check("middrain_popped", exp_a.size(), 0);
    exp_a.delete();
    #1;
    check_reset_outputs("middrain_rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_outputs("middrain_after");

    // Fresh set after reset
    out_ready_a = 1'b1;
    w = '{16'h0000, 16'h8000, 16'hC000, 16'hC400};
    s = '{16'hC400, 16'hC000, 16'h8000, 16'h0000};
    push_a(s, 4, 4);
    load_set(w, 1'b0);
    wait_idle_a(100);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp16_sort4.md
# fp16_sort4

Sequential four-entry sorter for 16-bit half-precision words (1 sign, 5 exponent, 10 mantissa bits). It accepts four operands over a valid/ready input stream and drives them pairwise through an internal registered compare stage. The compare stage uses the same {greater, less, equal} 3-bit result code as the datapath comparator. The sorter then returns the four words in order over a valid/ready output stream. It sits between the operand buffer and downstream min/max/median consumers in the FPU datapath, as the initiator side of the compare interface.

## Interface
- DESCEND, default 0: 0 = ascending output order, 1 = descending output order.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  16  FP16 operand.
- in_valid  input  1  in_data valid.
- in_ready  output  1  sorter accepts an operand; high only in LOAD.
- out_data  output  16  sorted word at the current drain index.
- out_valid  output  1  out_data valid; high only in DRAIN.
- out_ready  input  1  consumer accepts out_data.
- busy  output  1  high in CMP or SWAP.
- swap_count  output  3  number of swaps performed in the last sort; stable from DRAIN entry until the next sort starts.

## Operation
- Storage: four 16-bit registers r0..r3; 2-bit load/drain index idx; 3-bit pair index pk; 3-bit registered compare code cmp.
- Ordering rule, applied to compare(a, b), with result code {gt, lt, eq}:
  - Sign bits differ: positive > negative. This includes -0 (0x8000) < +0 (0x0000).
  - Both positive: unsigned compare of bits[14:0].
  - Both negative: larger bits[14:0] is less.
  - Identical words: eq = 001.
  - NaN and Inf are ordered by bit pattern under these rules, with no special casing.
- Sorting network: pairs in fixed order (0,1), (2,3), (0,2), (1,3), (1,2), with pk = 0..4.
- State machine:
  - LOAD: in_ready = 1. On in_valid, write r[idx] and increment idx. The 4th accept (idx = 3) goes to CMP with idx = 0, pk = 0, swap_count = 0.
  - CMP: cmp <= compare(r[a], r[b]) for pair pk. Go to SWAP.
  - SWAP: swap r[a] and r[b] when cmp = 100 (DESCEND = 0) or cmp = 010 (DESCEND = 1), and increment swap_count. Never swap on 001. If pk = 4, go to DRAIN with idx = 0; else increment pk and go to CMP.
  - DRAIN: out_valid = 1, out_data = r[idx]. On out_ready, increment idx. The 4th transfer goes to LOAD with idx = 0.
- in_valid outside LOAD is ignored and nothing is written. out_ready outside DRAIN is ignored.
- Reset (any state, including mid-sort or mid-drain):
  - Abort to LOAD; r0..r3 = 0, idx = 0, pk = 0, cmp = 000, swap_count = 0.
  - Output values during and after reset: in_ready = 1, out_valid = 0, out_data = 0, busy = 0, swap_count = 0.
  - Any partially loaded or undrained data is discarded.

## Timing
- Every compare-swap takes 2 cycles (registered compare, then swap), so a sort takes a fixed 10 cycles.
- If the 4th operand is accepted on edge T: busy is high in cycles T+1..T+10, and out_valid first rises in cycle T+11.
- Minimum back-to-back throughput is one 4-word set per 4 + 10 + 4 = 18 cycles.
- DRAIN backpressure: while out_ready = 0, out_data and out_valid hold unchanged with no cycle limit.
- in_ready drops in the cycle after the 4th accept, with no combinational path from in_valid. out_valid rises on the LOAD-to-DRAIN sequence only.
- swap_count is updated in SWAP cycles and is final when out_valid first rises.

## Test plan
- Ascending mixed signs: load 0x4200, 0x3C00, 0xC000, 0x4000 -> out 0xC000, 0x3C00, 0x4000, 0x4200; swap_count = 4; first out_valid 11 cycles after the 4th accept.
- Presorted and all-equal: load 0x3C00 x4 -> four 0x3C00 outputs, swap_count = 0. Load 0x0001, 0x0002, 0x0003, 0x0004 -> same order, swap_count = 0.
- Negatives and signed zero: load 0x0000, 0x8000, 0xC000, 0xC400 -> out 0xC400, 0xC000, 0x8000, 0x0000.
- DESCEND = 1: load 0x4200, 0x3C00, 0xC000, 0x4000 -> out 0x4200, 0x4000, 0x3C00, 0xC000.
- Handshake stress: randomly gate in_valid and out_ready, and assert in_valid during busy/DRAIN -> no extra writes; out_data held while out_ready = 0; no word lost or duplicated over 100 random sets checked against a reference model.
- Reset mid-sort (cycle T+5) and mid-drain (after 2 transfers) -> next cycle in LOAD: in_ready = 1, out_valid = 0, swap_count = 0. A following fresh set sorts correctly.
